// File: rtl/ccastles_video_timing.sv
// ccastles_video_timing: raster counters, blank/sync decode, line-group IRQ and frame-start pulse.
module ccastles_video_timing #(
  parameter int HTOTAL   = 320,
  parameter int HVIS     = 256,
  parameter int HS_START = 272,
  parameter int HS_END   = 304,
  parameter int VTOTAL   = 256,
  parameter int VVIS     = 232,
  parameter int VS_START = 240,
  parameter int VS_END   = 244
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic       irq_ack,
  output logic [8:0] hcount,
  output logic [7:0] vcount,
  output logic       HBlank,
  output logic       HSync,
  output logic       VBlank,
  output logic       VSync,
  output logic       irq,
  output logic       frame_start
);
  localparam logic [8:0] H_LAST = 9'(HTOTAL - 1);
  localparam logic [7:0] V_LAST = 8'(VTOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(HVIS);
  localparam logic [9:0] H_SS   = 10'(HS_START);
  localparam logic [9:0] H_SE   = 10'(HS_END);
  localparam logic [8:0] V_VIS  = 9'(VVIS);
  localparam logic [8:0] V_SS   = 9'(VS_START);
  localparam logic [8:0] V_SE   = 9'(VS_END);
  logic       h_wrap, v_wrap, irq_set;
  logic [8:0] h_nxt;
  logic [7:0] v_nxt;
  // Flags are decoded from the next counter values so they register alongside the counters.
  always_comb begin
    h_wrap  = hcount == H_LAST;
    v_wrap  = vcount == V_LAST;
    h_nxt   = h_wrap ? 9'd0 : hcount + 9'd1;
    v_nxt   = h_wrap ? (v_wrap ? 8'd0 : vcount + 8'd1) : vcount;
    irq_set = ce_pix && h_wrap && v_nxt[5:0] == 6'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount      <= '0;
      vcount      <= '0;
      HBlank      <= 1'b0;
      HSync       <= 1'b0;
      VBlank      <= 1'b0;
      VSync       <= 1'b0;
      irq         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= ce_pix && h_wrap && v_wrap;
      irq         <= irq_set || (irq && !irq_ack);
      if (ce_pix) begin
        hcount <= h_nxt;
        vcount <= v_nxt;
        HBlank <= {1'b0, h_nxt} >= H_VIS;
        HSync  <= {1'b0, h_nxt} >= H_SS && {1'b0, h_nxt} < H_SE;
        VBlank <= {1'b0, v_nxt} >= V_VIS;
        VSync  <= {1'b0, v_nxt} >= V_SS && {1'b0, v_nxt} < V_SE;
      end
    end
  end
endmodule
